mult_acc_ctrl: RTL and testbench
================================

Name: mult_acc_ctrl

Overview:
- Sequencer and accumulator wrapped around the 8x8 `mult` block.
- Accepts operand pairs over a valid/ready stream, drives `mult`'s a/b/start, and waits for done.
- Consumes each 16-bit product and sums the products of one group, which ends at the pair flagged last.
- Emits the accumulated sum and term count with a one-cycle valid pulse. This is the dot-product front end for the arithmetic datapath.

Parameters:
- ACC_W, 24, accumulator and acc_out width; must be >= 16.
- CNT_W, 8, term-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair.
- in_a  input  8  first operand.
- in_b  input  8  second operand.
- in_last  input  1  pair is the final term of the group.
- mul_a  output  8  to mult a.
- mul_b  output  8  to mult b.
- mul_start  output  1  to mult start.
- mul_r  input  16  from mult r.
- mul_done  input  1  from mult done.
- acc_out  output  ACC_W  group sum.
- term_cnt  output  CNT_W  terms in the group.
- acc_valid  output  1  one-cycle pulse: acc_out/term_cnt valid.
- overflow  output  1  sticky per group: the accumulator exceeded ACC_W bits.

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-multiply):
  - State goes to IDLE.
  - mul_start=0, mul_a=0, mul_b=0, acc_out=0, term_cnt=0, acc_valid=0, overflow=0.
  - Internal accumulator and counter go to 0; the latched last flag is cleared.
- FSM states: IDLE, BUSY, DRAIN, OUT.
- IDLE:
  - in_ready=1 (combinational from state), all other handshakes 0.
  - On in_valid && in_ready: register in_a→mul_a, in_b→mul_b, in_last→last_q, set mul_start=1, go to BUSY.
  - mul_done is ignored in IDLE.
- BUSY:
  - in_ready=0.
  - mul_start held 1; mul_a/mul_b held stable.
  - Multiplier latency is unbounded; wait for mul_done==1.
  - On the first cycle with mul_done==1:
    - acc ← acc + zero-extended mul_r.
    - cnt ← cnt+1, wrapping at 2^CNT_W.
    - mul_start ← 0.
    - Go to DRAIN.
- DRAIN:
  - in_ready=0, mul_start=0.
  - Wait for mul_done==0 so that a done still held high is never counted twice.
  - When mul_done==0: go to OUT if last_q, else go to IDLE.
- OUT (one cycle):
  - acc_out ← acc, term_cnt ← cnt, acc_valid=1.
  - overflow output ← sticky overflow.
  - Internal acc, cnt and sticky flag are cleared; next state is IDLE.
  - acc_out, term_cnt and overflow hold their values until the next OUT or reset.
- Latency per term: 1 (accept) + multiplier latency + 1 (BUSY capture) + ≥1 (DRAIN). acc_valid rises 1 cycle after the last DRAIN exit.
- Arithmetic:
  - Unsigned sum, computed in ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets the sticky overflow.
  - Without the optional feature the sum wraps modulo 2^ACC_W.
- Simultaneous events:
  - rst has priority over everything.
  - in_valid during BUSY, DRAIN or OUT is not accepted (in_ready=0); the source must hold the pair.
- A group of one term (in_last on the first pair) is legal.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined: on a carry out of ACC_W, acc saturates to 2^ACC_W-1 and stays there for the rest of the group; overflow is still set.
- Undefined: acc wraps modulo 2^ACC_W; overflow is set.
- All other behaviour is identical.

Test Plan:
- Bench provides a behavioural `mult` model with 9-cycle latency; done stays high until start drops.
- Single term: pair (3,4, last=1) → mul_a=3, mul_b=4, mul_start high until done. acc_valid pulses once with acc_out=12, term_cnt=1, overflow=0.
- Group: (3,4), (5,6), (10,10 last) → one acc_valid pulse only, with acc_out=142 and term_cnt=3. in_ready is low between accept and DRAIN exit.
- Overflow with ACC_W=16: (255,255), (255,255 last) →
  - Macro undefined: acc_out=64514, overflow=1.
  - MULT_ACC_SAT_EN defined: acc_out=65535, overflow=1.
  - A following group (2,2 last) → acc_out=4, overflow=0.
- Backpressure/done hold: in_valid held with new data (7,7) throughout BUSY, and model holds done high 5 cycles → exactly one accumulation per term. (7,7) is accepted only after DRAIN exits.
- Reset mid-operation: assert rst for 1 cycle while in BUSY after 2 terms → next cycle mul_start=0, in_ready=1, all outputs 0. A fresh group (1,1 last) → acc_out=1, term_cnt=1.

Source files
------------

// File: rtl/mult_acc_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mult_acc_ctrl_if
// Brief    : Operand stream, multiplier handshake and result bundle for
//            mult_acc_ctrl. The slave modport is the controller's view.
// Revision : 1.0  initial release
// ============================================================================
interface mult_acc_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  // operand stream
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  // multiplier handshake
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_start;
  logic [15:0]      mul_r;
  logic             mul_done;
  // group result
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] term_cnt;
  logic             acc_valid;
  logic             overflow;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_r, mul_done,
    output in_ready, mul_a, mul_b, mul_start, acc_out, term_cnt, acc_valid, overflow
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mul_r, mul_done,
    input  in_ready, mul_a, mul_b, mul_start, acc_out, term_cnt, acc_valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/mult_acc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mult_acc_ctrl
// Brief    : Sequencer around an 8x8 multiplier. Accepts operand pairs,
//            launches one multiply per pair, sums the 16-bit products of a
//            group (terminated by in_last) and emits the sum and term count
//            with a one-cycle acc_valid pulse.
// Options  : MULT_ACC_SAT_EN - when defined, the accumulator saturates at
//            2^ACC_W-1 on carry-out instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module mult_acc_ctrl #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  mult_acc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             ovf_q;

  logic [7:0]       mul_a_q;
  logic [7:0]       mul_b_q;
  logic             mul_start_q;
  logic [ACC_W-1:0] acc_out_q;
  logic [CNT_W-1:0] term_cnt_q;
  logic             acc_valid_q;
  logic             overflow_q;

  logic [ACC_W:0]   acc_sum;
  logic             acc_carry;
  logic [ACC_W-1:0] acc_d;

  // Next accumulator value: one extra bit catches the carry out of the top.
  always_comb begin
    acc_sum   = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, bus.mul_r};
    acc_carry = acc_sum[ACC_W];
`ifdef MULT_ACC_SAT_EN
    // Once saturated, every further add carries again, so it stays pinned.
    acc_d     = acc_carry ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
    acc_d     = acc_sum[ACC_W-1:0];
`endif
  end

  // Controller FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      acc_out_q   <= '0;
      term_cnt_q  <= '0;
      acc_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so valid alone is the handshake.
          if (bus.in_valid) begin
            mul_a_q     <= bus.in_a;
            mul_b_q     <= bus.in_b;
            last_q      <= bus.in_last;
            mul_start_q <= 1'b1;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.mul_done) begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_q + CNT_W'(1);
            ovf_q       <= ovf_q | acc_carry;
            mul_start_q <= 1'b0;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // A done still held high must not be captured as a second product.
          if (!bus.mul_done) begin
            state_q <= last_q ? S_OUT : S_IDLE;
          end
        end
        S_OUT: begin
          acc_out_q   <= acc_q;
          term_cnt_q  <= cnt_q;
          overflow_q  <= ovf_q;
          acc_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          last_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_start = mul_start_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.term_cnt  = term_cnt_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_acc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mult_acc_ctrl
// Brief    : Self-checking bench for mult_acc_ctrl with a behavioural 8x8
//            multiplier (9-cycle latency, done held until start drops).
//            Honours MULT_ACC_SAT_EN for the expected overflow result.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_acc_ctrl;

  localparam int ACC_W   = 16;
  localparam int CNT_W   = 8;
  localparam int MUL_LAT = 9;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
`ifdef MULT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   done_hold_min = 1;
  int   pulses = 0;
  int   groups_expected = 0;
  int   ga[$];
  int   gb[$];

  mult_acc_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus();

  mult_acc_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: latches a*b on start, raises done after the
  // latency, drops done once start is low and the minimum hold has elapsed.
  int   m_lat;
  int   m_hold;
  logic m_busy;
  always @(posedge clk) begin
    if (rst) begin
      m_busy       <= 1'b0;
      m_lat        <= 0;
      m_hold       <= 0;
      bus.mul_done <= 1'b0;
      bus.mul_r    <= '0;
    end else if (m_busy) begin
      if (m_lat == MUL_LAT - 1) begin
        m_busy       <= 1'b0;
        bus.mul_done <= 1'b1;
        m_hold       <= 1;
      end else begin
        m_lat <= m_lat + 1;
      end
    end else if (bus.mul_done) begin
      m_hold <= m_hold + 1;
      if (!bus.mul_start && m_hold >= done_hold_min) bus.mul_done <= 1'b0;
    end else if (bus.mul_start) begin
      m_busy    <= 1'b1;
      m_lat     <= 0;
      bus.mul_r <= {8'd0, bus.mul_a} * {8'd0, bus.mul_b};
    end
  end

  // Count every acc_valid cycle seen.
  always @(negedge clk) begin
    if (bus.acc_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 32'(t < 300), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mul_a", 32'(bus.mul_a), 32'(a));
    check("mul_b", 32'(bus.mul_b), 32'(b));
    check("mul_start", 32'(bus.mul_start), 32'd1);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag, input longint exp_acc, input int exp_cnt, input int exp_ovf);
    int t = 0;
    @(negedge clk);
    while (bus.acc_valid !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid_wait"}, 32'(t < 500), 32'd1);
    check({tag, "_acc_out"}, 32'(bus.acc_out), 32'(exp_acc));
    check({tag, "_term_cnt"}, 32'(bus.term_cnt), 32'(exp_cnt));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    @(negedge clk);
    check({tag, "_pulse_len"}, 32'(bus.acc_valid), 32'd0);
    check({tag, "_acc_hold"}, 32'(bus.acc_out), 32'(exp_acc));
  endtask

  // Sends the queued pairs as one group and checks against the arithmetic result.
  task automatic run_group(input string tag);
    longint total = 0;
    longint exp_acc;
    int     n = ga.size();
    for (int i = 0; i < n; i++) begin
      send_pair(8'(ga[i]), 8'(gb[i]), i == n - 1);
      total += longint'(ga[i]) * longint'(gb[i]);
    end
    if (total > ACC_MAX) exp_acc = SAT ? ACC_MAX : (total % (ACC_MAX + 1));
    else                 exp_acc = total;
    wait_result(tag, exp_acc, n % (1 << CNT_W), int'(total > ACC_MAX));
    groups_expected++;
    ga.delete();
    gb.delete();
  endtask

  initial begin
    int t;
    int busy_cycles;
    int ready_while_done;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_last  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mul_start", 32'(bus.mul_start), 32'd0);
    check("rst_acc_out", 32'(bus.acc_out), 32'd0);
    check("rst_term_cnt", 32'(bus.term_cnt), 32'd0);
    check("rst_acc_valid", 32'(bus.acc_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // single term
    ga = '{3}; gb = '{4};
    run_group("single");

    // three-term group
    ga = '{3, 5, 10}; gb = '{4, 6, 10};
    run_group("group3");

    // overflow, then a clean group
    ga = '{255, 255}; gb = '{255, 255};
    run_group("ovf");
    ga = '{2}; gb = '{2};
    run_group("after_ovf");

    // source holds the next pair through BUSY/DRAIN; done held 5 cycles
    done_hold_min = 5;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 8'd2; bus.in_b = 8'd3; bus.in_last = 1'b0;
    @(posedge clk);
    #1;
    bus.in_a = 8'd7; bus.in_b = 8'd7; bus.in_last = 1'b1;
    t = 0; busy_cycles = 0; ready_while_done = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 300) begin
      busy_cycles++;
      @(negedge clk);
      t++;
      if (bus.mul_done === 1'b1 && bus.in_ready === 1'b1) ready_while_done++;
    end
    check("bp_wait", 32'(t < 300), 32'd1);
    check("bp_no_ready_with_done", 32'(ready_while_done), 32'd0);
    check("bp_done_low_at_accept", 32'(bus.mul_done), 32'd0);
    check("bp_busy_span", 32'(busy_cycles >= MUL_LAT + 5), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_mul_a", 32'(bus.mul_a), 32'd7);
    wait_result("bp", 55, 2, 0);
    groups_expected++;
    done_hold_min = 1;

    // reset while the third term is in BUSY
    send_pair(8'd1, 8'd2, 1'b0);
    send_pair(8'd3, 8'd4, 1'b0);
    send_pair(8'd5, 8'd6, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_busy_start", 32'(bus.mul_start), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_mul_start", 32'(bus.mul_start), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_mul_a", 32'(bus.mul_a), 32'd0);
    check("mrst_mul_b", 32'(bus.mul_b), 32'd0);
    check("mrst_acc_out", 32'(bus.acc_out), 32'd0);
    check("mrst_term_cnt", 32'(bus.term_cnt), 32'd0);
    check("mrst_overflow", 32'(bus.overflow), 32'd0);
    ga = '{1}; gb = '{1};
    run_group("after_rst");

    // random groups
    for (int g = 0; g < 12; g++) begin
      int n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        ga.push_back(int'($urandom_range(0, 255)));
        gb.push_back(int'($urandom_range(0, 255)));
      end
      run_group("rand");
    end

    repeat (20) @(negedge clk);
    check("pulse_count", 32'(pulses), 32'(groups_expected));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
